mouse_top_level: RTL and testbench

PS/2 mouse front end for the DE1-SoC drawing design. Sends the enable-data-reporting command to the mouse on request, receives 3-byte stream packets, and tracks an on-screen cursor position clamped to the screen. Exposes button states and the cursor position. Also drives six seven-segment hex digits showing the position.

---
 rtl/mouse_pkg.sv | 22 ++
 rtl/seg7_lut.sv | 29 ++
 rtl/mouse_top_level.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mouse_top_level.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and PS/2 protocol constants for the mouse front end.
package mouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_STREAM
  } state_t;

  localparam logic [7:0]  CMD_ENABLE = 8'hF4;
  localparam logic [7:0]  PS2_ACK    = 8'hFA;
  localparam int unsigned FRAME_BITS = 11;

  // Parity bit value that makes the 9-bit group have an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Hex digit to active-low seven-segment pattern, bit order gfedcba.
module seg7_lut (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/mouse_top_level.sv
// PS/2 mouse front end: enables streaming on request, assembles packets,
// tracks a screen-clamped cursor and shows it on six hex digits.
module mouse_top_level
  import mouse_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  inout  wire         PS2_CLK,
  inout  wire         PS2_DAT,
  inout  wire  [35:0] GPIO_0,
  output logic        enable,
  output logic        clr,
  output logic        middle,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0
);

  // A zero cycle count falls back to the nominal 100 us / 2 ms at CLK_HZ.
  localparam int unsigned INH_LIM = (INHIBIT_CYCLES > 0) ? INHIBIT_CYCLES : CLK_HZ / 10_000;
  localparam int unsigned TO_LIM  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : CLK_HZ / 500;
  localparam int unsigned INH_W   = $clog2(INH_LIM + 1);
  localparam int unsigned TO_W    = $clog2(TO_LIM + 1);
  localparam logic signed [12:0] X_MAX = 13'(SCREEN_W - 1);
  localparam logic signed [12:0] Y_MAX = 13'(SCREEN_H - 1);
  localparam logic [10:0] X_RST = 11'(SCREEN_W / 2);
  localparam logic [10:0] Y_RST = 11'(SCREEN_H / 2);

  logic ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
  logic ps2d_meta_q, ps2d_sync_q;
  logic start_meta_q, start_sync_q, start_prev_q;
  logic fall, start_rise, rx_en, timeout;

  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]       tx_cnt_q, tx_cnt_d;
  logic             ack_pend_q, ack_pend_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;

  logic [TO_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_byte_q, rx_byte_d;

  logic [1:0]       pkt_idx_q, pkt_idx_d;
  logic [6:0]       hdr_q, hdr_d;   // {yov, xov, ysign, xsign, middle, right, left}
  logic [7:0]       dx_lo_q, dx_lo_d;
  logic [10:0]      x_q, x_d, y_q, y_d, x_clamp, y_clamp;
  logic [2:0]       btn_q, btn_d;
  logic signed [12:0] dx, dy, xs, ys;
  logic [7:0]       cmd;

  assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;
  assign GPIO_0  = {{34{1'bz}}, ps2d_sync_q, ps2c_sync_q};

  assign fall       = ps2c_prev_q & ~ps2c_sync_q;
  assign start_rise = start_sync_q & ~start_prev_q;
  assign timeout    = ~fall && (idle_cnt_q == TO_W'(TO_LIM - 1));
  assign rx_en      = (state_q == ST_IDLE) || (state_q == ST_STREAM) ||
                      ((state_q == ST_ACK) && !ack_pend_q);
  assign cmd        = CMD_ENABLE;

  // Receiver: frame bit counter, shifter and idle watchdog.
  always_comb begin
    idle_cnt_d = fall ? '0 : ((idle_cnt_q == TO_W'(TO_LIM)) ? idle_cnt_q : idle_cnt_q + 1'b1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    if (!rx_en || start_rise || timeout) begin
      bit_cnt_d = '0;
    end else if (fall) begin
      if (bit_cnt_q == 4'd0) begin
        if (!ps2d_sync_q) bit_cnt_d = 4'd1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {ps2d_sync_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        par_d     = ps2d_sync_q;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d = '0;
        if (ps2d_sync_q && (^{par_q, shift_q})) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = shift_q;
        end
      end
    end
  end

  // Control FSM; line drives are registered so they release on reset at once.
  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    ack_pend_d = ack_pend_q;
    clk_oe_d   = 1'b0;
    dat_oe_d   = 1'b0;
    if (start_rise) begin
      state_d   = ST_INHIBIT;
      inh_cnt_d = '0;
      clk_oe_d  = 1'b1;
    end else begin
      unique case (state_q)
        ST_INHIBIT: begin
          if (inh_cnt_q == INH_W'(INH_LIM - 1)) begin
            state_d  = ST_REQ;
            dat_oe_d = 1'b1;
          end else begin
            inh_cnt_d = inh_cnt_q + 1'b1;
            clk_oe_d  = 1'b1;
          end
        end
        ST_REQ: begin
          dat_oe_d = 1'b1;
          tx_cnt_d = '0;
          state_d  = ST_SEND;
        end
        ST_SEND: begin
          dat_oe_d = dat_oe_q;
          if (fall) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            if (tx_cnt_q < 4'd8) begin
              dat_oe_d = ~cmd[tx_cnt_q[2:0]];
            end else if (tx_cnt_q == 4'd8) begin
              dat_oe_d = ~odd_parity(CMD_ENABLE);
            end else begin
              dat_oe_d   = 1'b0;
              ack_pend_d = 1'b1;
              state_d    = ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (ack_pend_q && fall) ack_pend_d = 1'b0;
          if (rx_valid_q) state_d = (rx_byte_q == PS2_ACK) ? ST_STREAM : ST_IDLE;
          else if (timeout) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Packet assembly and clamped position update.
  always_comb begin
    dx = hdr_q[5] ? '0 : {{4{hdr_q[3]}}, hdr_q[3], dx_lo_q};
    dy = hdr_q[6] ? '0 : {{4{hdr_q[4]}}, hdr_q[4], rx_byte_q};
    xs = $signed({2'b00, x_q}) + dx;
    ys = $signed({2'b00, y_q}) - dy;
    if (xs < 0)          x_clamp = '0;
    else if (xs > X_MAX) x_clamp = X_MAX[10:0];
    else                 x_clamp = xs[10:0];
    if (ys < 0)          y_clamp = '0;
    else if (ys > Y_MAX) y_clamp = Y_MAX[10:0];
    else                 y_clamp = ys[10:0];

    pkt_idx_d = pkt_idx_q;
    hdr_d     = hdr_q;
    dx_lo_d   = dx_lo_q;
    x_d       = x_q;
    y_d       = y_q;
    btn_d     = btn_q;
    if ((state_q == ST_STREAM) && rx_valid_q) begin
      unique case (pkt_idx_q)
        2'd0: if (rx_byte_q[3]) begin
          hdr_d     = {rx_byte_q[7:4], rx_byte_q[2:0]};
          pkt_idx_d = 2'd1;
        end
        2'd1: begin
          dx_lo_d   = rx_byte_q;
          pkt_idx_d = 2'd2;
        end
        default: begin
          x_d       = x_clamp;
          y_d       = y_clamp;
          btn_d     = hdr_q[2:0];
          pkt_idx_d = 2'd0;
        end
      endcase
    end
    if (start_rise || timeout || (state_q != ST_STREAM)) pkt_idx_d = 2'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_meta_q  <= 1'b1;
      ps2c_sync_q  <= 1'b1;
      ps2c_prev_q  <= 1'b1;
      ps2d_meta_q  <= 1'b1;
      ps2d_sync_q  <= 1'b1;
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      state_q      <= ST_IDLE;
      inh_cnt_q    <= '0;
      tx_cnt_q     <= '0;
      ack_pend_q   <= 1'b0;
      clk_oe_q     <= 1'b0;
      dat_oe_q     <= 1'b0;
      idle_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= '0;
      pkt_idx_q    <= '0;
      hdr_q        <= '0;
      dx_lo_q      <= '0;
      x_q          <= X_RST;
      y_q          <= Y_RST;
      btn_q        <= '0;
    end else begin
      ps2c_meta_q  <= PS2_CLK;
      ps2c_sync_q  <= ps2c_meta_q;
      ps2c_prev_q  <= ps2c_sync_q;
      ps2d_meta_q  <= PS2_DAT;
      ps2d_sync_q  <= ps2d_meta_q;
      start_meta_q <= start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      state_q      <= state_d;
      inh_cnt_q    <= inh_cnt_d;
      tx_cnt_q     <= tx_cnt_d;
      ack_pend_q   <= ack_pend_d;
      clk_oe_q     <= clk_oe_d;
      dat_oe_q     <= dat_oe_d;
      idle_cnt_q   <= idle_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      rx_valid_q   <= rx_valid_d;
      rx_byte_q    <= rx_byte_d;
      pkt_idx_q    <= pkt_idx_d;
      hdr_q        <= hdr_d;
      dx_lo_q      <= dx_lo_d;
      x_q          <= x_d;
      y_q          <= y_d;
      btn_q        <= btn_d;
    end
  end

  assign enable = btn_q[0];
  assign clr    = btn_q[1];
  assign middle = btn_q[2];
  assign x      = x_q;
  assign y      = y_q;

  seg7_lut u_hex5 (.hex({1'b0, x_q[10:8]}), .seg(hex5));
  seg7_lut u_hex4 (.hex(x_q[7:4]),          .seg(hex4));
  seg7_lut u_hex3 (.hex(x_q[3:0]),          .seg(hex3));
  seg7_lut u_hex2 (.hex({1'b0, y_q[10:8]}), .seg(hex2));
  seg7_lut u_hex1 (.hex(y_q[7:4]),          .seg(hex1));
  seg7_lut u_hex0 (.hex(y_q[3:0]),          .seg(hex0));

endmodule

// File: tb/tb_mouse_top_level.sv
// Bench for mouse_top_level: models a PS/2 mouse on the lines and predicts
// cursor/button state arithmetically from the packet rules.
module tb_mouse_top_level;

  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int HALF = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  wire  PS2_CLK, PS2_DAT;
  wire  [35:0] GPIO_0;
  logic enable, clr, middle;
  logic [10:0] x, y;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;

  int vectors = 0;
  int miscompares = 0;
  int mx = 320;
  int my = 240;
  logic [2:0] mbtn = 3'b000;

  assign PS2_CLK = dev_clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT = dev_dat_low ? 1'b0 : 1'bz;
  pullup (PS2_CLK);
  pullup (PS2_DAT);

  mouse_top_level #(
    .CLK_HZ(50_000_000), .SCREEN_W(640), .SCREEN_H(480),
    .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT), .GPIO_0(GPIO_0),
    .enable(enable), .clr(clr), .middle(middle), .x(x), .y(y),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input int v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v & 15];
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dev_bit(input logic b);
    dev_dat_low = !b;
    wait_cycles(HALF);
    dev_clk_low = 1'b1;
    wait_cycles(HALF);
    dev_clk_low = 1'b0;
  endtask

  task automatic dev_send(input logic [7:0] b, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(b[i]);
    dev_bit(p);
    dev_bit(1'b1);
    wait_cycles(HALF);
  endtask

  // Sends one packet, predicts the result, and checks that x/y/buttons move together.
  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input string tag);
    int dxv, dyv, ex, ey, lat;
    logic [2:0] eb;
    logic [10:0] px, py;
    logic [2:0] pb;
    bit partial;
    dxv = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dyv = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    ex = clampi(mx + dxv, 639);
    ey = clampi(my - dyv, 479);
    eb = b0[2:0];
    dev_send(b0, 1'b0);
    dev_send(b1, 1'b0);
    dev_bit(1'b0);
    for (int i = 0; i < 8; i++) dev_bit(b2[i]);
    dev_bit(~^b2);
    dev_dat_low = 1'b0;
    wait_cycles(HALF);
    px = x; py = y; pb = {middle, clr, enable};
    dev_clk_low = 1'b1;
    lat = 0;
    partial = 1'b0;
    while (lat < 20 && !(x == 11'(ex) && y == 11'(ey) && {middle, clr, enable} == eb)) begin
      wait_cycles(1);
      lat++;
      if (!((x == px && y == py && {middle, clr, enable} == pb) ||
            (x == 11'(ex) && y == 11'(ey) && {middle, clr, enable} == eb))) partial = 1'b1;
    end
    vectors++;
    if (x !== 11'(ex) || y !== 11'(ey) || {middle, clr, enable} !== eb) begin
      miscompares++;
      $display("FAIL %s: got x=%0d y=%0d btn=%b, want x=%0d y=%0d btn=%b", tag, x, y,
               {middle, clr, enable}, ex, ey, eb);
    end
    vectors++;
    if (partial) begin
      miscompares++;
      $display("FAIL %s_same_cycle: outputs updated in different cycles, want one update", tag);
    end
    wait_cycles(HALF);
    dev_clk_low = 1'b0;
    wait_cycles(HALF);
    mx = ex; my = ey; mbtn = eb;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(5);
    vectors++; if (x !== 11'd320) begin miscompares++; $display("FAIL reset_x: got %0d want 320", x); end
    vectors++; if (y !== 11'd240) begin miscompares++; $display("FAIL reset_y: got %0d want 240", y); end
    vectors++; if ({middle, clr, enable} !== 3'b000) begin miscompares++;
      $display("FAIL reset_btn: got %b want 000", {middle, clr, enable}); end
    vectors++; if (hex5 !== seg_ref(1) || hex4 !== seg_ref(4) || hex3 !== seg_ref(0)) begin
      miscompares++; $display("FAIL reset_hex_x: got %h %h %h want %h %h %h", hex5, hex4, hex3,
                              seg_ref(1), seg_ref(4), seg_ref(0)); end
    vectors++; if (hex2 !== seg_ref(0) || hex1 !== seg_ref(15) || hex0 !== seg_ref(0)) begin
      miscompares++; $display("FAIL reset_hex_y: got %h %h %h want %h %h %h", hex2, hex1, hex0,
                              seg_ref(0), seg_ref(15), seg_ref(0)); end
    vectors++; if (PS2_CLK !== 1'b1 || PS2_DAT !== 1'b1) begin miscompares++;
      $display("FAIL reset_lines: got clk=%b dat=%b want 1 1", PS2_CLK, PS2_DAT); end
    vectors++; if (GPIO_0[1:0] !== 2'b11) begin miscompares++;
      $display("FAIL reset_gpio: got %b want 11", GPIO_0[1:0]); end
  endtask

  task automatic test_idle_ignore();
    dev_send(8'h09, 1'b0);
    dev_send(8'h40, 1'b0);
    dev_send(8'h40, 1'b0);
    wait_cycles(10);
    vectors++;
    if (x !== 11'd320 || y !== 11'd240 || enable !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignore: got x=%0d y=%0d en=%b want 320 240 0", x, y, enable);
    end
  endtask

  task automatic test_start();
    int t, low;
    logic [9:0] rx;
    start = 1'b0;
    wait_cycles(4);
    start = 1'b1;
    t = 0;
    while (PS2_CLK !== 1'b0 && t < 100) begin wait_cycles(1); t++; end
    vectors++;
    if (t >= 100) begin miscompares++; $display("FAIL start_inhibit: clock not pulled low, want low within 100 clks"); end
    low = 0;
    while (PS2_CLK === 1'b0 && low < 4 * INH) begin wait_cycles(1); low++; end
    vectors++;
    if (low < INH || low >= 4 * INH) begin miscompares++;
      $display("FAIL start_inhibit_len: got %0d clks low want >= %0d", low, INH); end
    wait_cycles(2);
    vectors++;
    if (PS2_DAT !== 1'b0) begin miscompares++; $display("FAIL start_req: got dat=%b want 0", PS2_DAT); end
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      wait_cycles(HALF);
      dev_clk_low = 1'b0;
      wait_cycles(HALF / 2);
      rx[i] = PS2_DAT;
      wait_cycles(HALF / 2);
    end
    vectors++;
    if (rx[7:0] !== 8'hF4) begin miscompares++; $display("FAIL start_cmd: got %h want f4", rx[7:0]); end
    vectors++;
    if (rx[9:8] !== 2'b10) begin miscompares++; $display("FAIL start_par_stop: got par=%b stop=%b want 0 1", rx[8], rx[9]); end
    dev_dat_low = 1'b1;
    wait_cycles(HALF / 2);
    dev_clk_low = 1'b1;
    wait_cycles(HALF);
    dev_clk_low = 1'b0;
    wait_cycles(HALF / 2);
    dev_dat_low = 1'b0;
    wait_cycles(HALF);
    dev_send(8'hFA, 1'b0);
  endtask

  task automatic test_packets();
    send_packet(8'h09, 8'h05, 8'h00, "pkt_left_dx5");
    send_packet(8'h28, 8'h00, 8'hF6, "pkt_dy_neg10");
    send_packet(8'h18, 8'h80, 8'h00, "pkt_dx_m128_a");
    send_packet(8'h18, 8'h80, 8'h00, "pkt_dx_m128_b");
    send_packet(8'h18, 8'hC0, 8'h00, "pkt_to_x5");
    send_packet(8'h18, 8'h80, 8'h00, "clamp_x_low");
    send_packet(8'h18, 8'hFF, 8'h00, "clamp_x0_m1");
    send_packet(8'h0E, 8'hFF, 8'h00, "pkt_right_mid");
    send_packet(8'h08, 8'hFF, 8'h00, "pkt_dx255_a");
    send_packet(8'h08, 8'hFF, 8'h00, "pkt_dx255_b");
    send_packet(8'h08, 8'hFF, 8'h00, "clamp_x_high");
    send_packet(8'h08, 8'h01, 8'h00, "clamp_x639_p1");
    send_packet(8'h48, 8'h7F, 8'h00, "x_overflow");
    send_packet(8'h08, 8'h00, 8'hFF, "clamp_y_high");
    send_packet(8'h88, 8'h00, 8'h10, "y_overflow");
  endtask

  task automatic test_bad_parity();
    dev_send(8'h09, 1'b1);
    dev_send(8'h01, 1'b0);
    send_packet(8'h09, 8'h03, 8'h02, "after_bad_parity");
  endtask

  task automatic test_timeout();
    dev_send(8'h08, 1'b0);
    dev_send(8'h10, 1'b0);
    wait_cycles(TO + 300);
    send_packet(8'h0A, 8'h04, 8'h00, "after_pkt_gap");
    dev_bit(1'b0);
    dev_bit(1'b1);
    dev_bit(1'b0);
    dev_dat_low = 1'b0;
    wait_cycles(TO + 300);
    send_packet(8'h3C, 8'hF0, 8'hF8, "after_frame_gap");
  endtask

  task automatic test_random();
    logic [7:0] b0;
    for (int n = 0; n < 16; n++) begin
      b0 = 8'($urandom) | 8'h08;
      if ($urandom_range(3) != 0) b0[7:6] = 2'b00;
      send_packet(b0, 8'($urandom), 8'($urandom), "random_pkt");
    end
    vectors++;
    if (hex5 !== seg_ref(mx >> 8) || hex4 !== seg_ref(mx >> 4) || hex3 !== seg_ref(mx)) begin
      miscompares++; $display("FAIL random_hex_x: got %h %h %h for x=%0d", hex5, hex4, hex3, mx); end
    vectors++;
    if (hex2 !== seg_ref(my >> 8) || hex1 !== seg_ref(my >> 4) || hex0 !== seg_ref(my)) begin
      miscompares++; $display("FAIL random_hex_y: got %h %h %h for y=%0d", hex2, hex1, hex0, my); end
  endtask

  task automatic test_reset_midsend();
    int t;
    start = 1'b0;
    wait_cycles(4);
    start = 1'b1;
    t = 0;
    while (PS2_CLK !== 1'b0 && t < 100) begin wait_cycles(1); t++; end
    wait_cycles(10);
    reset = 1'b0;
    #1;
    vectors++;
    if (PS2_CLK !== 1'b1 || PS2_DAT !== 1'b1) begin miscompares++;
      $display("FAIL reset_mid_lines: got clk=%b dat=%b want 1 1", PS2_CLK, PS2_DAT); end
    vectors++;
    if (x !== 11'd320 || y !== 11'd240 || {middle, clr, enable} !== 3'b000) begin miscompares++;
      $display("FAIL reset_mid_state: got x=%0d y=%0d btn=%b want 320 240 000", x, y, {middle, clr, enable}); end
    start = 1'b0;
    wait_cycles(3);
    reset = 1'b1;
    mx = 320; my = 240; mbtn = 3'b000;
    wait_cycles(5);
    test_start();
    send_packet(8'h29, 8'h20, 8'h08, "after_reset_pkt");
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, want finish before 5 ms");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_start();
    test_packets();
    test_bad_parity();
    test_timeout();
    test_random();
    test_reset_midsend();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
